// File: rtl/fp_cvt_pkg.sv
// Shared configuration and stage payload types for the linear-to-float converter.
// The default widths below are the only configuration the stage structs support.
package fp_cvt_pkg;

    localparam int CVT_IN_W  = 12;
    localparam int CVT_EXP_W = 3;
    localparam int CVT_SIG_W = 4;
    localparam int EXP_MAX   = 2**CVT_EXP_W - 1;

    // The input must hold exactly one significand plus every exponent step.
    function automatic bit cfg_ok(input int inW, input int expW, input int sigW);
        return inW == sigW + 2**expW;
    endfunction

    typedef struct packed {
        logic                 s;
        logic [CVT_IN_W-1:0]  mag;
        logic                 rnd;
    } mag_stage_t;

    typedef struct packed {
        logic                 s;
        logic [CVT_SIG_W-1:0] sig;
        logic [CVT_EXP_W-1:0] exp;
        logic                 fifth;
        logic                 rnd;
    } norm_stage_t;

endpackage

// File: rtl/fp_cvt_pipe_normalize.sv
// Combinational normaliser: leading-zero count of the magnitude, then
// exponent, significand window and the first dropped bit used for rounding.
module fp_normalize
    import fp_cvt_pkg::*;
#(
    parameter int IN_W  = CVT_IN_W,
    parameter int EXP_W = CVT_EXP_W,
    parameter int SIG_W = CVT_SIG_W
) (
    input  logic [IN_W-1:0]  mag_i,
    output logic [EXP_W-1:0] exp_o,
    output logic [SIG_W-1:0] sig_o,
    output logic             fifth_o
);

    localparam int LZ_W = $clog2(IN_W + 1);

    logic [LZ_W-1:0] lz;
    logic [LZ_W-1:0] shiftAmt;

    // Ascending scan: the last set bit found is the most significant one.
    always_comb begin
        lz = LZ_W'(IN_W);
        for (int i = 0; i < IN_W; i++) begin
            if (mag_i[i]) begin
                lz = LZ_W'(IN_W - 1 - i);
            end
        end
        shiftAmt = LZ_W'(2**EXP_W) - lz;
        exp_o    = '0;
        sig_o    = mag_i[SIG_W-1:0];
        fifth_o  = 1'b0;
        if (lz < LZ_W'(2**EXP_W)) begin
            exp_o   = EXP_W'(shiftAmt);
            sig_o   = SIG_W'(mag_i >> shiftAmt);
            fifth_o = mag_i[shiftAmt - LZ_W'(1)];
        end
    end

endmodule

// File: rtl/fp_cvt_pipe.sv
// Three-stage linear-to-float converter (sign/magnitude, normalise, round)
// with a valid/ready stream interface; all stages stall together.
module fp_cvt_pipe
    import fp_cvt_pkg::*;
#(
    parameter int IN_W  = CVT_IN_W,
    parameter int EXP_W = CVT_EXP_W,
    parameter int SIG_W = CVT_SIG_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [IN_W-1:0]  d,
    input  logic             rnd_en,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             s,
    output logic [EXP_W-1:0] e,
    output logic [SIG_W-1:0] f
);

    if (!cfg_ok(IN_W, EXP_W, SIG_W) || IN_W != CVT_IN_W ||
        EXP_W != CVT_EXP_W || SIG_W != CVT_SIG_W) begin : g_cfg_err
        $error("fp_cvt_pipe: unsupported width configuration");
    end

    logic             adv;
    logic             v1_q, v2_q, v3_q;
    mag_stage_t       s1_d, s1_q;
    norm_stage_t      s2_d, s2_q;
    logic             s_d, s_q;
    logic [EXP_W-1:0] e_d, e_q;
    logic [SIG_W-1:0] f_d, f_q;
    logic [EXP_W-1:0] nExp;
    logic [SIG_W-1:0] nSig;
    logic             nFifth;
    logic [IN_W-1:0]  magAbs;
    logic [SIG_W:0]   sigInc;

    assign adv       = !v3_q || out_ready;
    assign in_ready  = adv;
    assign out_valid = v3_q;
    assign s         = s_q;
    assign e         = e_q;
    assign f         = f_q;

    // The most negative sample has no positive twin, so it saturates.
    always_comb begin
        if (!d[IN_W-1]) begin
            magAbs = d;
        end else if (d == {1'b1, {(IN_W-1){1'b0}}}) begin
            magAbs = {1'b0, {(IN_W-1){1'b1}}};
        end else begin
            magAbs = -d;
        end
        s1_d = '{s: d[IN_W-1], mag: magAbs, rnd: rnd_en};
    end

    fp_normalize #(.IN_W(IN_W), .EXP_W(EXP_W), .SIG_W(SIG_W)) u_normalize (
        .mag_i   (s1_q.mag),
        .exp_o   (nExp),
        .sig_o   (nSig),
        .fifth_o (nFifth)
    );

    assign s2_d = '{s: s1_q.s, sig: nSig, exp: nExp, fifth: nFifth, rnd: s1_q.rnd};

    // A carry out of the significand renormalises to 1000.. and bumps the
    // exponent; at the top exponent the code clamps to the largest value.
    always_comb begin
        sigInc = {1'b0, s2_q.sig} + (SIG_W+1)'(1);
        s_d    = s2_q.s;
        e_d    = s2_q.exp;
        f_d    = s2_q.sig;
        if (s2_q.rnd && s2_q.fifth) begin
            if (sigInc[SIG_W]) begin
                if (s2_q.exp == EXP_W'(EXP_MAX)) begin
                    f_d = '1;
                end else begin
                    e_d = s2_q.exp + EXP_W'(1);
                    f_d = {1'b1, {(SIG_W-1){1'b0}}};
                end
            end else begin
                f_d = sigInc[SIG_W-1:0];
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            v1_q <= 1'b0;
            v2_q <= 1'b0;
            v3_q <= 1'b0;
            s1_q <= '0;
            s2_q <= '0;
            s_q  <= 1'b0;
            e_q  <= '0;
            f_q  <= '0;
        end else if (adv) begin
            v1_q <= in_valid;
            v2_q <= v1_q;
            v3_q <= v2_q;
            if (in_valid) begin
                s1_q <= s1_d;
            end
            if (v1_q) begin
                s2_q <= s2_d;
            end
            // Outputs keep the last result through bubbles.
            if (v2_q) begin
                s_q <= s_d;
                e_q <= e_d;
                f_q <= f_d;
            end
        end
    end

endmodule

// File: doc/fp_cvt_pipe.md
Name: fp_cvt_pipe

Overview:
- Pipelined, parametrised converter from a two's-complement linear sample to a compact floating-point code {S, E, F}.
- Adds two behaviours the current single-cycle extractor lacks: round-half-up with mantissa and exponent overflow handling, and a valid/ready stream interface with backpressure.
- Sits between the sample source and the display/encode path.
- One input accepted per cycle when not stalled.

Parameters:
- IN_W, 12: input width (two's complement). Must equal SIG_W + 2**EXP_W.
- EXP_W, 3: exponent width.
- SIG_W, 4: significand width. No hidden bit.

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous, active-high reset.
- in_valid  in  1  input sample valid.
- in_ready  out  1  block can accept a sample this cycle.
- d  in  IN_W  two's-complement sample.
- rnd_en  in  1  1 = round half-up, 0 = truncate. Sampled with d.
- out_valid  out  1  result valid.
- out_ready  in  1  downstream accepts the result.
- s  out  1  sign.
- e  out  EXP_W  exponent.
- f  out  SIG_W  significand.

Behaviour:
- Reset (async assert, sync deassert by design convention):
  - All stage valids, out_valid, s, e and f clear to 0.
  - Any in-flight data is discarded.
  - in_ready is 1 in the first cycle after reset releases.
- Handshake and stall:
  - adv = !out_valid || out_ready, and in_ready = adv.
  - Input transfers when in_valid && in_ready. Output transfers when out_valid && out_ready.
  - When adv = 0, every stage holds its register contents.
  - When adv = 1, all three stages shift together. A bubble enters stage 1 if in_valid = 0.
  - Latency is 3 cycles from input transfer to out_valid, with no stall.
  - Throughput is 1 sample/cycle while out_ready stays high.
  - Results leave in input order. No sample is dropped or duplicated.
  - While stalled, s/e/f/out_valid stay stable.
- Stage 1, sign/magnitude:
  - s = d[IN_W-1].
  - mag = |d|, IN_W bits unsigned.
  - Most-negative input (-2**(IN_W-1)) saturates to mag = 2**(IN_W-1)-1.
  - Latch rnd_en alongside.
- Stage 2, normalise:
  - lz = leading zeros of mag.
  - If lz >= 2**EXP_W: exp = 0, sig = mag[SIG_W-1:0], fifth = 0.
  - Otherwise: exp = 2**EXP_W - lz, sig = mag[exp+SIG_W-1 : exp], fifth = mag[exp-1].
- Stage 3, round:
  - If rnd_en && fifth: sig' = sig + 1.
  - If sig' overflows (2**SIG_W):
    - sig' = 1 followed by SIG_W-1 zeros, and exp increments.
    - If exp was already max (2**EXP_W-1), saturate to e = max, f = all ones.
  - If !rnd_en, or fifth = 0: f = sig, e = exp.
  - s is passed through unchanged. Zero input gives s=0, e=0, f=0.
- No X propagation: stage data registers load only on adv, but are reset to 0.

Decomposition:
- Package fp_cvt_pkg holds:
  - IN_W, EXP_W and SIG_W defaults.
  - The constant EXP_MAX = 2**EXP_W-1.
  - A localparam check function enforcing IN_W == SIG_W + 2**EXP_W.
  - The stage-payload struct {s, mag/sig, exp, fifth, rnd}.
- One natural combinational sub-module, fp_normalize: lz count plus the exp/sig/fifth extraction, instantiated in stage 2.
- Rounding and pipeline control stay in the top module.

Test Plan:
- d=12'd0, rnd_en=1 -> s=0 e=0 f=4'b0000, out_valid exactly 3 cycles after transfer.
- d=12'd422 (0001_1010_0110) -> s=0 e=5 f=4'b1101. d=-422 -> s=1 e=5 f=4'b1101.
- d=12'd46 -> rnd_en=1: e=2 f=4'b1100. rnd_en=0: e=2 f=4'b1011.
- d=12'd125 with rnd_en=1 -> mantissa overflow: e=4 f=4'b1000.
- d=-2048 and d=2047, both rnd_en=1 -> exponent saturation, e=7 f=4'b1111. s=1 and s=0 respectively.
- Backpressure: stream samples 1..6 with in_valid=1 and hold out_ready=0 for 5 cycles:
  - in_ready drops once the pipe is full.
  - outputs stay stable while stalled.
  - after release, all 6 results emerge in order, none lost.
  - rst asserted mid-stream -> out_valid=0 immediately, no stale result appears afterwards.
